// File: rtl/nbody_pkg.sv
// Shared types and limits for the n-body force accumulator.
// Holds the 16-bit force type, the accumulator FSM state enum and the force clamp limits.
package nbody_pkg;

    typedef logic signed [15:0] force_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } acc_state_e;

    localparam force_t FORCE_MAX = 16'sh7FFF;
    localparam force_t FORCE_MIN = 16'sh8000;

endpackage

// File: rtl/force_accumulator_if.sv
// Contribution stream and output-buffer write port of the force accumulator.
// The master drives contributions and observes writes; the slave is the accumulator.
interface force_accumulator_if #(
    parameter int IDX_BITS = 8
);
    import nbody_pkg::*;

    logic                P_VALID;
    logic                P_READY;
    logic [IDX_BITS-1:0] P_IDX;
    force_t              P_FX;
    force_t              P_FY;
    logic                P_LAST;
    logic                WR_EN;
    logic [IDX_BITS-1:0] WR_IDX;
    force_t              FORCE_X;
    force_t              FORCE_Y;

    modport master (
        output P_VALID, P_IDX, P_FX, P_FY, P_LAST,
        input  P_READY, WR_EN, WR_IDX, FORCE_X, FORCE_Y
    );

    modport slave (
        input  P_VALID, P_IDX, P_FX, P_FY, P_LAST,
        output P_READY, WR_EN, WR_IDX, FORCE_X, FORCE_Y
    );

endinterface

// File: rtl/sat_adder.sv
// Saturating W-bit signed accumulate of a 16-bit force, plus a clamp of the
// current accumulator value to the 16-bit force range, both with clamp indication.
module sat_adder
    import nbody_pkg::*;
#(
    parameter int W = 24
) (
    input  logic signed [W-1:0] i_acc,
    input  force_t              i_add,
    output logic signed [W-1:0] o_sum,
    output logic                o_sum_sat,
    output force_t              o_narrow,
    output logic                o_narrow_sat
);
    localparam logic signed [W-1:0] ACC_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-16:0]       TOP_ZERO = {(W-15){1'b0}};
    localparam logic [W-16:0]       TOP_ONES = {(W-15){1'b1}};

    logic signed [W:0] w_wide;

    assign w_wide = {i_acc[W-1], i_acc} + {{(W-15){i_add[15]}}, i_add};

    // Wide sum overflowed when its two top bits disagree; the extra bit gives the direction.
    always_comb begin
        o_sum     = w_wide[W-1:0];
        o_sum_sat = 1'b0;
        if (w_wide[W] != w_wide[W-1]) begin
            o_sum_sat = 1'b1;
            o_sum     = w_wide[W] ? ACC_MIN : ACC_MAX;
        end else begin
            o_sum     = w_wide[W-1:0];
        end
    end

    // Accumulator fits in 16 bits only when everything from bit 15 up is a sign copy.
    always_comb begin
        o_narrow     = i_acc[15:0];
        o_narrow_sat = 1'b0;
        if ((i_acc[W-1:15] != TOP_ZERO) && (i_acc[W-1:15] != TOP_ONES)) begin
            o_narrow_sat = 1'b1;
            o_narrow     = i_acc[W-1] ? FORCE_MIN : FORCE_MAX;
        end else begin
            o_narrow     = i_acc[15:0];
        end
    end

endmodule

// File: rtl/force_accumulator.sv
// Per-body signed force accumulation, saturated and written to the output buffer each frame.
// Optional sticky SAT_FLAG output exists only when FORCE_ACC_SAT_FLAG_EN is defined.
module force_accumulator
    import nbody_pkg::*;
#(
    parameter int N        = 256,
    parameter int IDX_BITS = $clog2(N),
    parameter int ACC_W    = 24
) (
    input  logic               CLK_IN,
    input  logic               RESET_IN,
    input  logic               START,
    force_accumulator_if.slave bus,
    output logic               CLEAR_OUT,
    output logic               FRAME_VALID,
    input  logic               OUT_DONE,
    output logic               BUSY
`ifdef FORCE_ACC_SAT_FLAG_EN
    ,
    output logic               SAT_FLAG
`endif
);
    localparam logic [IDX_BITS:0] CNT_LAST = (IDX_BITS+1)'(N - 1);
    localparam logic [IDX_BITS:0] CNT_N    = (IDX_BITS+1)'(N);
    localparam logic [IDX_BITS:0] CNT_ONE  = (IDX_BITS+1)'(1);
    localparam logic [IDX_BITS:0] CNT_ZERO = (IDX_BITS+1)'(0);

    typedef logic signed [ACC_W-1:0] acc_t;
    localparam acc_t ACC_ZERO = {ACC_W{1'b0}};

    acc_state_e          r_state;
    acc_state_e          w_next_state;
    logic [IDX_BITS:0]   r_cnt;
    logic [IDX_BITS:0]   w_cnt_next;
    acc_t                r_acc_x [N];
    acc_t                r_acc_y [N];

    logic                r_p_ready;
    logic                r_wr_en;
    logic                r_clear_out;
    logic                r_frame_valid;
    logic                r_busy;
    logic [IDX_BITS-1:0] r_wr_idx;
    force_t              r_force_x;
    force_t              r_force_y;

    logic                w_fire;
    logic                w_idx_ok;
    logic                w_drain_wr;
    logic                w_mem_wr;
    logic [IDX_BITS-1:0] w_mem_idx;
    logic [IDX_BITS-1:0] w_rd_idx;
    acc_t                w_mem_x;
    acc_t                w_mem_y;
    acc_t                w_rd_x;
    acc_t                w_rd_y;
    acc_t                w_sum_x;
    acc_t                w_sum_y;
    logic                w_sum_sat_x;
    logic                w_sum_sat_y;
    force_t              w_nar_x;
    force_t              w_nar_y;
    logic                w_nar_sat_x;
    logic                w_nar_sat_y;

    assign w_fire     = bus.P_VALID && r_p_ready;
    assign w_idx_ok   = ({1'b0, bus.P_IDX} < CNT_N);
    assign w_drain_wr = (r_state == DRAIN) && (r_cnt != CNT_N);
    assign w_rd_idx   = (r_state == DRAIN) ? r_cnt[IDX_BITS-1:0] : bus.P_IDX;
    assign w_rd_x     = r_acc_x[w_rd_idx];
    assign w_rd_y     = r_acc_y[w_rd_idx];

    sat_adder #(.W(ACC_W)) u_sat_x (
        .i_acc        (w_rd_x),
        .i_add        (bus.P_FX),
        .o_sum        (w_sum_x),
        .o_sum_sat    (w_sum_sat_x),
        .o_narrow     (w_nar_x),
        .o_narrow_sat (w_nar_sat_x)
    );

    sat_adder #(.W(ACC_W)) u_sat_y (
        .i_acc        (w_rd_y),
        .i_add        (bus.P_FY),
        .o_sum        (w_sum_y),
        .o_sum_sat    (w_sum_sat_y),
        .o_narrow     (w_nar_y),
        .o_narrow_sat (w_nar_sat_y)
    );

    // Next state and shared ZERO/DRAIN index counter.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_next = CNT_ZERO;
                if (START) w_next_state = ZERO;
                else       w_next_state = IDLE;
            end
            ZERO: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = ACCUM;
                    w_cnt_next   = CNT_ZERO;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ACCUM: begin
                w_cnt_next = CNT_ZERO;
                if (w_fire && bus.P_LAST) w_next_state = DRAIN;
                else                      w_next_state = ACCUM;
            end
            DRAIN: begin
                if (r_cnt == CNT_N) begin
                    w_next_state = HOLD;
                    w_cnt_next   = CNT_ZERO;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            HOLD: begin
                w_cnt_next = CNT_ZERO;
                if (OUT_DONE) w_next_state = IDLE;
                else          w_next_state = HOLD;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Single accumulator write port: clearing in ZERO, saturated sums on an in-range fire.
    always_comb begin
        w_mem_wr  = 1'b0;
        w_mem_idx = r_cnt[IDX_BITS-1:0];
        w_mem_x   = ACC_ZERO;
        w_mem_y   = ACC_ZERO;
        if (r_state == ZERO) begin
            w_mem_wr  = 1'b1;
        end else if (w_fire && w_idx_ok) begin
            w_mem_wr  = 1'b1;
            w_mem_idx = bus.P_IDX;
            w_mem_x   = w_sum_x;
            w_mem_y   = w_sum_y;
        end else begin
            w_mem_wr  = 1'b0;
        end
    end

    // Accumulator storage is deliberately not reset; ZERO clears it at the start of every frame.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN && w_mem_wr) begin
            r_acc_x[w_mem_idx] <= w_mem_x;
            r_acc_y[w_mem_idx] <= w_mem_y;
        end
    end

    // Registered outputs; status flags follow the state being entered.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_p_ready     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_clear_out   <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_idx      <= {IDX_BITS{1'b0}};
            r_force_x     <= 16'sd0;
            r_force_y     <= 16'sd0;
        end else begin
            r_p_ready     <= (w_next_state == ACCUM);
            r_busy        <= (w_next_state != IDLE);
            r_frame_valid <= (w_next_state == HOLD);
            r_clear_out   <= (r_state == IDLE) && START;
            r_wr_en       <= w_drain_wr;
            if (w_drain_wr) begin
                r_wr_idx  <= r_cnt[IDX_BITS-1:0];
                r_force_x <= w_nar_x;
                r_force_y <= w_nar_y;
            end else begin
                r_wr_idx  <= r_wr_idx;
                r_force_x <= r_force_x;
                r_force_y <= r_force_y;
            end
        end
    end

    assign bus.P_READY = r_p_ready;
    assign bus.WR_EN   = r_wr_en;
    assign bus.WR_IDX  = r_wr_idx;
    assign bus.FORCE_X = r_force_x;
    assign bus.FORCE_Y = r_force_y;
    assign CLEAR_OUT   = r_clear_out;
    assign FRAME_VALID = r_frame_valid;
    assign BUSY        = r_busy;

`ifdef FORCE_ACC_SAT_FLAG_EN
    logic r_sat_flag;

    // Sticky clamp indicator for the current frame.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_sat_flag <= 1'b0;
        end else if ((r_state == IDLE) && START) begin
            r_sat_flag <= 1'b0;
        end else if ((w_mem_wr && (r_state == ACCUM) && (w_sum_sat_x || w_sum_sat_y)) ||
                     (w_drain_wr && (w_nar_sat_x || w_nar_sat_y))) begin
            r_sat_flag <= 1'b1;
        end else begin
            r_sat_flag <= r_sat_flag;
        end
    end

    assign SAT_FLAG = r_sat_flag;
`else
    logic w_unused_sat;
    assign w_unused_sat = ^{w_sum_sat_x, w_sum_sat_y, w_nar_sat_x, w_nar_sat_y};
`endif

endmodule
